// File: rtl/id_ex_forward_if.sv
// Signal bundle between the ID/EX hazard stage and the surrounding pipeline.
// The stage itself connects through the slave modport.
interface id_ex_forward_if #(
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 16
);
  logic               flush;
  logic               id_valid;
  logic [4:0]         id_rs;
  logic [4:0]         id_rt;
  logic [4:0]         id_rd;
  logic               id_uses_rt;
  logic [31:0]        id_rdata1;
  logic [31:0]        id_rdata2;
  logic [31:0]        id_imm;
  logic               id_regwrite;
  logic               id_memread;
  logic               id_memwrite;
  logic               id_alusrc;
  logic [ALUOP_W-1:0] id_aluop;
  logic               mem_regwrite;
  logic [4:0]         mem_rd;
  logic [31:0]        mem_result;
  logic               wb_regwrite;
  logic [4:0]         wb_rd;
  logic [31:0]        wb_data;

  logic               stall;
  logic               ex_valid;
  logic [4:0]         ex_rd;
  logic               ex_regwrite;
  logic               ex_memread;
  logic               ex_memwrite;
  logic [ALUOP_W-1:0] ex_aluop;
  logic [31:0]        ex_opA;
  logic [31:0]        ex_opB;
  logic [31:0]        ex_aluB;
  logic [1:0]         fwd_a;
  logic [1:0]         fwd_b;
  logic [CNT_W-1:0]   bubble_count;

  modport master (
    output flush, id_valid, id_rs, id_rt, id_rd, id_uses_rt, id_rdata1, id_rdata2, id_imm,
           id_regwrite, id_memread, id_memwrite, id_alusrc, id_aluop,
           mem_regwrite, mem_rd, mem_result, wb_regwrite, wb_rd, wb_data,
    input  stall, ex_valid, ex_rd, ex_regwrite, ex_memread, ex_memwrite, ex_aluop,
           ex_opA, ex_opB, ex_aluB, fwd_a, fwd_b, bubble_count
  );

  modport slave (
    input  flush, id_valid, id_rs, id_rt, id_rd, id_uses_rt, id_rdata1, id_rdata2, id_imm,
           id_regwrite, id_memread, id_memwrite, id_alusrc, id_aluop,
           mem_regwrite, mem_rd, mem_result, wb_regwrite, wb_rd, wb_data,
    output stall, ex_valid, ex_rd, ex_regwrite, ex_memread, ex_memwrite, ex_aluop,
           ex_opA, ex_opB, ex_aluB, fwd_a, fwd_b, bubble_count
  );
endinterface

// File: rtl/id_ex_forward_stage.sv
// ID/EX pipeline register with WB->ID bypass, load-use stall and bubble insertion,
// and EX/MEM / MEM/WB forwarding onto the EX-stage operands.
module id_ex_forward_stage #(
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 16
) (
  input logic            clk,
  input logic            reset,
  id_ex_forward_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // r0 is hardwired, so a write targeting it never matches a reader.
  function automatic logic hit(input logic we, input logic [4:0] wr, input logic [4:0] rr);
    return we && (wr != 5'd0) && (wr == rr);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] r,
                                         input logic mem_we, input logic [4:0] mem_rd,
                                         input logic wb_we,  input logic [4:0] wb_rd);
    if (hit(mem_we, mem_rd, r)) return 2'd2;
    if (hit(wb_we, wb_rd, r))   return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] fwd_mux(input logic [1:0] sel, input logic [31:0] reg_val,
                                          input logic [31:0] mem_val, input logic [31:0] wb_val);
    case (sel)
      2'd2:    return mem_val;
      2'd1:    return wb_val;
      default: return reg_val;
    endcase
  endfunction

  logic               valid_p1, regwrite_p1, memread_p1, memwrite_p1, alusrc_p1;
  logic [4:0]         rs_p1, rt_p1, rd_p1;
  logic [ALUOP_W-1:0] aluop_p1;
  logic [CNT_W-1:0]   bubbles_p1;
  logic [31:0]        data1_p1, data2_p1, imm_p1;

  logic [31:0]        rdata1_p0, rdata2_p0;
  logic               load_use_p0, bubble_p0;
  logic [1:0]         fwd_a_p1, fwd_b_p1;
  logic [31:0]        opa_p1, opb_p1;

  // ---- ID stage: same-cycle WB bypass and load-use detection ----
  always_comb begin
    rdata1_p0   = hit(bus.wb_regwrite, bus.wb_rd, bus.id_rs) ? bus.wb_data : bus.id_rdata1;
    rdata2_p0   = hit(bus.wb_regwrite, bus.wb_rd, bus.id_rt) ? bus.wb_data : bus.id_rdata2;
    load_use_p0 = bus.id_valid && !bus.flush && valid_p1 && memread_p1 && (rd_p1 != 5'd0) &&
                  ((rd_p1 == bus.id_rs) || (bus.id_uses_rt && (rd_p1 == bus.id_rt)));
    bubble_p0   = bus.flush || load_use_p0;
  end

  // ---- ID/EX register: control with reset/bubble precedence ----
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_p1    <= 1'b0;
      regwrite_p1 <= 1'b0;
      memread_p1  <= 1'b0;
      memwrite_p1 <= 1'b0;
      alusrc_p1   <= 1'b0;
      aluop_p1    <= '0;
      rs_p1       <= 5'd0;
      rt_p1       <= 5'd0;
      rd_p1       <= 5'd0;
      bubbles_p1  <= '0;
    end else if (bubble_p0) begin
      valid_p1    <= 1'b0;
      regwrite_p1 <= 1'b0;
      memread_p1  <= 1'b0;
      memwrite_p1 <= 1'b0;
      alusrc_p1   <= 1'b0;
      aluop_p1    <= '0;
      rs_p1       <= 5'd0;
      rt_p1       <= 5'd0;
      rd_p1       <= 5'd0;
      bubbles_p1  <= sat_inc(bubbles_p1);
    end else begin
      valid_p1    <= bus.id_valid;
      regwrite_p1 <= bus.id_valid && bus.id_regwrite;
      memread_p1  <= bus.id_valid && bus.id_memread;
      memwrite_p1 <= bus.id_valid && bus.id_memwrite;
      alusrc_p1   <= bus.id_valid && bus.id_alusrc;
      aluop_p1    <= bus.id_valid ? bus.id_aluop : '0;
      rs_p1       <= bus.id_rs;
      rt_p1       <= bus.id_rt;
      rd_p1       <= bus.id_rd;
    end
  end

  // Operand data always loads; on a bubble it is simply ignored downstream.
  always_ff @(posedge clk) begin
    data1_p1 <= rdata1_p0;
    data2_p1 <= rdata2_p0;
    imm_p1   <= bus.id_imm;
  end

  // ---- EX stage: operand forwarding ----
  always_comb begin
    fwd_a_p1 = fwd_sel(rs_p1, bus.mem_regwrite, bus.mem_rd, bus.wb_regwrite, bus.wb_rd);
    fwd_b_p1 = fwd_sel(rt_p1, bus.mem_regwrite, bus.mem_rd, bus.wb_regwrite, bus.wb_rd);
    opa_p1   = fwd_mux(fwd_a_p1, data1_p1, bus.mem_result, bus.wb_data);
    opb_p1   = fwd_mux(fwd_b_p1, data2_p1, bus.mem_result, bus.wb_data);
  end

  assign bus.stall        = load_use_p0;
  assign bus.ex_valid     = valid_p1;
  assign bus.ex_rd        = rd_p1;
  assign bus.ex_regwrite  = regwrite_p1;
  assign bus.ex_memread   = memread_p1;
  assign bus.ex_memwrite  = memwrite_p1;
  assign bus.ex_aluop     = aluop_p1;
  assign bus.ex_opA       = opa_p1;
  assign bus.ex_opB       = opb_p1;
  assign bus.ex_aluB      = alusrc_p1 ? imm_p1 : opb_p1;
  assign bus.fwd_a        = fwd_a_p1;
  assign bus.fwd_b        = fwd_b_p1;
  assign bus.bubble_count = bubbles_p1;

endmodule

// File: tb/tb_id_ex_forward_stage.sv
// Bench for id_ex_forward_stage: directed scenarios with literal expectations plus a
// randomized run checked every cycle against an architectural model of the stage.
module tb_id_ex_forward_stage;
  localparam int ALUOP_W = 3;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_ex_forward_if #(.ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) bus ();

  id_ex_forward_stage #(.ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Architectural register file as committed at each clock edge.
  logic [31:0] rf [32];

  // Model of what the EX stage holds: the last instruction admitted, or a bubble.
  bit                 started = 0;
  logic               m_valid, m_regwrite, m_memread, m_memwrite, m_alusrc;
  logic [4:0]         m_rd, m_rs, m_rt;
  logic [ALUOP_W-1:0] m_aluop;
  logic [31:0]        m_d1, m_d2, m_imm;
  int                 m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic model_stall();
    return bus.id_valid && !bus.flush && m_valid && m_memread && (m_rd != 5'd0) &&
           ((m_rd == bus.id_rs) || (bus.id_uses_rt && (m_rd == bus.id_rt)));
  endfunction

  // Youngest in-flight producer of register r wins; r0 never has a producer.
  function automatic logic [1:0] model_src(input logic [4:0] r);
    if (r == 5'd0) return 2'd0;
    if (bus.mem_regwrite && bus.mem_rd == r) return 2'd2;
    if (bus.wb_regwrite && bus.wb_rd == r) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] model_val(input logic [4:0] r, input logic [31:0] held);
    case (model_src(r))
      2'd2:    return bus.mem_result;
      2'd1:    return bus.wb_data;
      default: return held;
    endcase
  endfunction

  initial begin : model_update
    forever begin
      logic st;
      @(posedge clk);
      st = model_stall();
      if (bus.wb_regwrite && bus.wb_rd != 5'd0) rf[bus.wb_rd] = bus.wb_data;
      if (reset) begin
        m_valid = 0; m_regwrite = 0; m_memread = 0; m_memwrite = 0; m_alusrc = 0;
        m_aluop = '0; m_rd = 0; m_cnt = 0;
      end else if (bus.flush || st) begin
        m_valid = 0; m_regwrite = 0; m_memread = 0; m_memwrite = 0; m_alusrc = 0;
        m_aluop = '0;
        if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      end else begin
        m_valid    = bus.id_valid;
        m_regwrite = bus.id_regwrite;
        m_memread  = bus.id_memread;
        m_memwrite = bus.id_memwrite;
        m_alusrc   = bus.id_alusrc;
        m_aluop    = bus.id_aluop;
        m_rd       = bus.id_rd;
        m_rs       = bus.id_rs;
        m_rt       = bus.id_rt;
        m_d1       = rf[bus.id_rs];
        m_d2       = rf[bus.id_rt];
        m_imm      = bus.id_imm;
      end
      started = 1;
    end
  end

  initial begin : compare
    forever begin
      logic [31:0] ea, eb;
      @(negedge clk);
      if (started) begin
        check("stall",        32'(bus.stall),        32'(model_stall()));
        check("ex_valid",     32'(bus.ex_valid),     32'(m_valid));
        check("bubble_count", 32'(bus.bubble_count), 32'(m_cnt));
        check("ex_regwrite",  32'(bus.ex_regwrite),  32'(m_regwrite));
        check("ex_memread",   32'(bus.ex_memread),   32'(m_memread));
        check("ex_memwrite",  32'(bus.ex_memwrite),  32'(m_memwrite));
        check("ex_aluop",     32'(bus.ex_aluop),     32'(m_aluop));
        check("data_known",   32'(!$isunknown({bus.ex_opA, bus.ex_opB, bus.ex_aluB})), 32'd1);
        if (m_valid) begin
          ea = model_val(m_rs, m_d1);
          eb = model_val(m_rt, m_d2);
          check("ex_rd",   32'(bus.ex_rd), 32'(m_rd));
          check("fwd_a",   32'(bus.fwd_a), 32'(model_src(m_rs)));
          check("fwd_b",   32'(bus.fwd_b), 32'(model_src(m_rt)));
          check("ex_opA",  bus.ex_opA, ea);
          check("ex_opB",  bus.ex_opB, eb);
          check("ex_aluB", bus.ex_aluB, m_alusrc ? m_imm : eb);
        end
      end
    end
  end

  task automatic idle();
    bus.flush = 0; bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0;
    bus.id_uses_rt = 0; bus.id_imm = 0; bus.id_regwrite = 0; bus.id_memread = 0;
    bus.id_memwrite = 0; bus.id_alusrc = 0; bus.id_aluop = '0;
    bus.mem_regwrite = 0; bus.mem_rd = 0; bus.mem_result = 0;
    bus.wb_regwrite = 0; bus.wb_rd = 0; bus.wb_data = 0;
    bus.id_rdata1 = rf[0]; bus.id_rdata2 = rf[0];
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic uses_rt, input logic regwrite, input logic memread,
                       input logic memwrite, input logic alusrc,
                       input logic [ALUOP_W-1:0] aluop, input logic [31:0] imm);
    bus.id_valid = 1; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd; bus.id_uses_rt = uses_rt;
    bus.id_regwrite = regwrite; bus.id_memread = memread; bus.id_memwrite = memwrite;
    bus.id_alusrc = alusrc; bus.id_aluop = aluop; bus.id_imm = imm;
    bus.id_rdata1 = rf[rs]; bus.id_rdata2 = rf[rt];
  endtask

  // Advance one edge; the register file outputs follow the newly committed state.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.id_rdata1 = rf[bus.id_rs];
    bus.id_rdata2 = rf[bus.id_rt];
  endtask

  initial begin : stimulus
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    reset = 1;
    idle();
    tick(); tick();
    reset = 0;
    @(negedge clk);
    check("t1_ex_valid", 32'(bus.ex_valid),     32'd0);
    check("t1_bubbles",  32'(bus.bubble_count), 32'd0);
    check("t1_stall",    32'(bus.stall),        32'd0);

    // WB writes r5 while ID reads a stale r5.
    tick(); idle();
    issue(5'd5, 5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 32'd0);
    bus.wb_regwrite = 1; bus.wb_rd = 5'd5; bus.wb_data = 32'hDEADBEEF;
    tick(); idle();
    @(negedge clk);
    check("t2_ex_valid", 32'(bus.ex_valid), 32'd1);
    check("t2_opA",      bus.ex_opA,        32'hDEADBEEF);
    check("t2_fwd_a",    32'(bus.fwd_a),    32'd0);

    // lw r8 followed by a dependent add.
    tick(); idle();
    issue(5'd0, 5'd0, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 32'd4);
    tick(); idle();
    issue(5'd8, 5'd0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 32'd0);
    @(negedge clk);
    check("t3_stall", 32'(bus.stall), 32'd1);
    tick();
    bus.mem_regwrite = 1; bus.mem_rd = 5'd8; bus.mem_result = 32'd4;
    @(negedge clk);
    check("t3_bubble_valid", 32'(bus.ex_valid),     32'd0);
    check("t3_bubbles",      32'(bus.bubble_count), 32'd1);
    check("t3_stall_clear",  32'(bus.stall),        32'd0);
    tick(); idle();
    bus.wb_regwrite = 1; bus.wb_rd = 5'd8; bus.wb_data = 32'h55;
    @(negedge clk);
    check("t3_add_valid", 32'(bus.ex_valid), 32'd1);
    check("t3_fwd_a",     32'(bus.fwd_a),    32'd1);
    check("t3_opA",       bus.ex_opA,        32'h55);

    // EX/MEM and MEM/WB both target r3.
    tick(); idle();
    issue(5'd3, 5'd0, 5'd11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    tick(); idle();
    bus.mem_regwrite = 1; bus.mem_rd = 5'd3; bus.mem_result = 32'h11;
    bus.wb_regwrite  = 1; bus.wb_rd  = 5'd3; bus.wb_data    = 32'h22;
    @(negedge clk);
    check("t4_fwd_a", 32'(bus.fwd_a), 32'd2);
    check("t4_opA",   bus.ex_opA,     32'h11);

    // Pending writes to r0 never forward.
    tick(); idle();
    issue(5'd0, 5'd0, 5'd12, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    tick(); idle();
    bus.mem_regwrite = 1; bus.mem_rd = 5'd0; bus.mem_result = 32'hA0;
    bus.wb_regwrite  = 1; bus.wb_rd  = 5'd0; bus.wb_data    = 32'hB0;
    @(negedge clk);
    check("t5_fwd_a", 32'(bus.fwd_a), 32'd0);
    check("t5_opA",   bus.ex_opA,     32'd0);

    // Flush together with a load-use hazard, then saturate the counter.
    tick(); idle();
    issue(5'd0, 5'd0, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 32'd8);
    tick(); idle();
    issue(5'd7, 5'd7, 5'd13, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    bus.flush = 1;
    @(negedge clk);
    check("t6_stall_suppressed", 32'(bus.stall), 32'd0);
    tick(); idle();
    @(negedge clk);
    check("t6_bubble_valid", 32'(bus.ex_valid),     32'd0);
    check("t6_bubbles",      32'(bus.bubble_count), 32'd2);
    tick(); idle(); bus.flush = 1;
    repeat (CNT_MAX + 4) tick();
    @(negedge clk);
    check("t6_saturated", 32'(bus.bubble_count), 32'(CNT_MAX));
    tick();
    @(negedge clk);
    check("t6_holds_max", 32'(bus.bubble_count), 32'(CNT_MAX));

    // Reset arriving while a load-use stall is active.
    tick(); idle();
    issue(5'd0, 5'd0, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 32'd12);
    tick(); idle();
    issue(5'd6, 5'd0, 5'd14, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    reset = 1;
    @(negedge clk);
    check("t7_stall", 32'(bus.stall), 32'd1);
    tick(); reset = 0;
    @(negedge clk);
    check("t7_valid",   32'(bus.ex_valid),     32'd0);
    check("t7_stall",   32'(bus.stall),        32'd0);
    check("t7_bubbles", 32'(bus.bubble_count), 32'd0);

    // Randomized traffic over a small register window to provoke hazards.
    for (int c = 0; c < 3000; c++) begin
      tick();
      idle();
      reset     = ($urandom_range(0, 63) == 0);
      bus.flush = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) != 0)
        issue(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ALUOP_W'($urandom), $urandom);
      bus.mem_regwrite = 1'($urandom_range(0, 1));
      bus.mem_rd       = 5'($urandom_range(0, 7));
      bus.mem_result   = $urandom;
      bus.wb_regwrite  = 1'($urandom_range(0, 1));
      bus.wb_rd        = 5'($urandom_range(0, 7));
      bus.wb_data      = $urandom;
    end
    tick(); reset = 0; idle();
    tick(); tick();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
